// File: rtl/apb_regfile_bridge.sv
// apb_regfile_bridge: APB3 slave turning transfers into register-file strobes with PSLVERR decode
module apb_regfile_bridge #(
  parameter int NUM_REGS  = 6,
  parameter int RF_ADDR_W = 5,
  parameter int PADDR_W   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [PADDR_W-1:0]   paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 rf_cs,
  output logic                 rf_wren,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [31:0]          rf_wdata,
  input  logic [31:0]          rf_rdata
);
  typedef enum logic [2:0] {IDLE, WR_CMD, RD_CMD, RD_CAP, RESP} state_t;
  state_t state, state_d;
  logic [31:0] prdata_d, rf_wdata_d;
  logic pready_d, pslverr_d, rf_cs_d, rf_wren_d;
  logic [RF_ADDR_W-1:0] rf_addr_d;
  logic [PADDR_W-3:0] idx;
  logic err, setup, abort;
  assign idx   = paddr[PADDR_W-1:2];
  assign err   = (paddr[1:0] != 2'b00) || (idx >= (PADDR_W-2)'(NUM_REGS));
  assign setup = psel && !penable;
  assign abort = !psel;
  always_comb begin
    state_d    = state;
    prdata_d   = prdata;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    rf_cs_d    = 1'b0;
    rf_wren_d  = 1'b0;
    rf_addr_d  = rf_addr;
    rf_wdata_d = rf_wdata;
    case (state)
      IDLE: if (setup) begin
        if (err) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else begin
          state_d    = pwrite ? WR_CMD : RD_CMD;
          rf_cs_d    = 1'b1;
          rf_wren_d  = pwrite;
          rf_addr_d  = idx[RF_ADDR_W-1:0];
          rf_wdata_d = pwdata;
        end
      end
      WR_CMD: begin
        state_d  = abort ? IDLE : RESP;
        pready_d = !abort;
        prdata_d = abort ? prdata : '0;
      end
      RD_CMD: state_d = abort ? IDLE : RD_CAP;
      RD_CAP: begin
        state_d  = abort ? IDLE : RESP;
        pready_d = !abort;
        prdata_d = abort ? prdata : rf_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      rf_cs    <= 1'b0;
      rf_wren  <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      state    <= state_d;
      prdata   <= prdata_d;
      pready   <= pready_d;
      pslverr  <= pslverr_d;
      rf_cs    <= rf_cs_d;
      rf_wren  <= rf_wren_d;
      rf_addr  <= rf_addr_d;
      rf_wdata <= rf_wdata_d;
    end
  end
endmodule

// File: tb/tb_apb_regfile_bridge.sv
// tb_apb_regfile_bridge: directed and randomized APB transfers checked against a register-array model
module tb_apb_regfile_bridge;
  logic clk, rst, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata, rf_wdata, rf_rdata;
  logic pready, pslverr, rf_cs, rf_wren;
  logic [4:0] rf_addr;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [8];
  int checks = 0, failures = 0, cs_pulses = 0, viol = 0;
  logic [4:0] last_addr;
  logic last_wren;
  apb_regfile_bridge dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rf_cs(rf_cs), .rf_wren(rf_wren), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_rdata <= '0;
    end else begin
      if (rf_cs && rf_wren) mem[rf_addr] <= rf_wdata;
      if (rf_cs && !rf_wren) rf_rdata <= mem[rf_addr];
    end
    if (rf_cs) begin
      cs_pulses <= cs_pulses + 1;
      last_addr <= rf_addr;
      last_wren <= rf_wren;
    end
    if (rf_wren && !rf_cs) viol <= viol + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      psel = 1'b0;
      penable = 1'b0;
    end
  endtask
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d);
    int n, cs0, exp_n;
    logic e;
    logic [31:0] exp_rd;
    e = (a[1:0] != 2'b00) || (a[11:2] >= 10'd6);
    exp_n = e ? 1 : (wr ? 2 : 3);
    exp_rd = (e || wr) ? 32'h0 : ref_mem[a[4:2]];
    cs0 = cs_pulses;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    n = 0;
    do begin
      @(negedge clk);
      penable = 1'b1;
      n++;
    end while (!pready && n < 10);
    check("pready_seen", {31'b0, pready}, 32'd1);
    check("latency", n, exp_n);
    check("pslverr", {31'b0, pslverr}, {31'b0, e});
    check("prdata", prdata, exp_rd);
    check("cs_pulses", cs_pulses - cs0, e ? 0 : 1);
    if (!e) begin
      check("rf_addr", {27'b0, last_addr}, {22'b0, a[11:2]});
      check("rf_wren", {31'b0, last_wren}, {31'b0, wr});
      if (wr) ref_mem[a[4:2]] = d;
    end
  endtask
  initial begin
    int cs0;
    logic wr;
    logic [11:0] a;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_rf_cs", {31'b0, rf_cs}, 32'd0);
    rst = 1'b0;
    // reset while the read strobe is on the bus
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(negedge clk);
    penable = 1'b1;
    check("rd_cmd_cs", {31'b0, rf_cs}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    check("midrst_outs", {prdata, rf_wdata}, 64'h0);
    check("midrst_ctl", {26'b0, pready, pslverr, rf_cs, rf_wren, 2'b0}, 32'd0);
    check("midrst_addr", {27'b0, rf_addr}, 32'd0);
    @(negedge clk);
    check("midrst_no_pready", {31'b0, pready}, 32'd0);
    // write then read
    xfer(1'b1, 12'h008, 32'hDEADBEEF);
    idle(2);
    xfer(1'b0, 12'h008, 32'h0);
    idle(1);
    // out of range and misaligned
    xfer(1'b0, 12'h018, 32'h0);
    idle(1);
    xfer(1'b1, 12'h7FC, 32'hCAFEF00D);
    idle(1);
    xfer(1'b1, 12'h004, 32'hA5A5A5A5);
    idle(1);
    xfer(1'b1, 12'h005, 32'h11111111);
    idle(1);
    xfer(1'b0, 12'h004, 32'h0);
    idle(1);
    // back-to-back
    cs0 = cs_pulses;
    xfer(1'b1, 12'h014, 32'h12345678);
    xfer(1'b0, 12'h014, 32'h0);
    check("b2b_cs_total", cs_pulses - cs0, 2);
    idle(1);
    // penable without setup
    cs0 = cs_pulses;
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; paddr = 12'h000;
    repeat (3) begin
      @(negedge clk);
      check("stray_penable_pready", {31'b0, pready}, 32'd0);
    end
    check("stray_penable_cs", cs_pulses - cs0, 0);
    idle(1);
    // abort in RD_CMD
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(negedge clk);
    psel = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_pready", {31'b0, pready}, 32'd0);
    end
    xfer(1'b0, 12'h000, 32'h0);
    idle(1);
    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 12'($urandom_range(0, 4095));
        1: a = {10'($urandom_range(0, 5)), 2'($urandom_range(1, 3))};
        default: a = {10'($urandom_range(0, 5)), 2'b00};
      endcase
      xfer(wr, a, $urandom);
      idle($urandom_range(0, 2));
    end
    check("wren_without_cs", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_regfile_bridge.md
Name: apb_regfile_bridge

Overview:
APB3 slave front-end that sits directly upstream of the register file. It converts APB transfers into the register file's cs/wren/addr/data strobes and returns read data with APB wait states. It also decodes out-of-range and misaligned addresses into PSLVERR, so these accesses never reach the register file.

Parameters:
NUM_REGS, 6, number of implemented 32-bit registers; word index >= NUM_REGS is an error
RF_ADDR_W, 5, width of register-file address bus
PADDR_W, 12, APB byte-address width

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous reset, active-high
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1=write, 0=read
paddr  input  PADDR_W  byte address; word index = paddr[PADDR_W-1:2]
pwdata  input  32  write data
prdata  output  32  read data, valid when pready=1
pready  output  1  transfer complete
pslverr  output  1  error response, valid only with pready
rf_cs  output  1  register-file chip select
rf_wren  output  1  register-file write enable
rf_addr  output  RF_ADDR_W  register-file word address
rf_wdata  output  32  register-file write data
rf_rdata  input  32  register-file read data; registered, valid 1 cycle after cs=1,wren=0

Behaviour:
- All outputs are registered. rst=1 at a rising edge forces state=IDLE and prdata=0, pready=0, pslverr=0, rf_cs=0, rf_wren=0, rf_addr=0, rf_wdata=0. This overrides any operation in progress, including a regfile strobe about to issue.
- States: IDLE, WR_CMD, RD_CMD, RD_CAP, RESP.
- IDLE: on an edge with psel=1 and penable=0 (setup phase), latch addr, pwdata and pwrite, then check for errors.
  - Error if paddr[1:0]!=0 or paddr[PADDR_W-1:2] >= NUM_REGS.
  - Error -> RESP with pslverr=1 and prdata=0. No rf_cs is ever issued.
  - Valid write -> WR_CMD. Drive rf_cs=1, rf_wren=1, rf_addr=index, rf_wdata=pwdata.
  - Valid read -> RD_CMD. Drive rf_cs=1, rf_wren=0, rf_addr=index.
- WR_CMD (1 cycle): the register file commits at the end of this cycle. Next: rf_cs=0, rf_wren=0, go to RESP.
- RD_CMD (1 cycle): the register file captures the read at the end of this cycle. Next: rf_cs=0, go to RD_CAP.
- RD_CAP (1 cycle): rf_rdata is valid. Latch prdata<=rf_rdata, go to RESP.
- RESP: pready=1 for exactly one cycle, with pslverr per the decode. Next state is IDLE; pready and pslverr return to 0.
- Latency, counted in access-phase cycles including the pready cycle:
  - error: 1 (zero wait)
  - write: 2 (one wait)
  - read: 3 (two waits)
- rf_cs is high for exactly one cycle per valid transfer and never for an error transfer. rf_wren is never high without rf_cs.
- prdata holds its last value between transfers. Write and error responses force prdata=0 in RESP.
- Back-to-back: a setup phase in the cycle immediately after the pready cycle is accepted. A setup phase seen while the bridge is not in IDLE is ignored.
- Abort: if psel=0 in WR_CMD, RD_CMD or RD_CAP, the in-flight regfile operation still completes. The RESP pready pulse is suppressed and the bridge returns to IDLE.
- penable=1 seen in IDLE without a preceding setup is ignored (no response).
- rf_addr and rf_wdata hold their values after the strobe until the next transfer.

Test Plan:
1. Reset: assert rst for 2 cycles mid-read (in RD_CMD) -> next cycle all outputs 0, state IDLE, no pready.
2. Write then read: write paddr=0x008, pwdata=0xDEADBEEF -> one rf_cs+rf_wren pulse with rf_addr=2, pready on the 2nd access cycle, pslverr=0. Then read 0x008 -> rf_cs with wren=0, pready on the 3rd access cycle, prdata=0xDEADBEEF.
3. Out of range: read paddr=0x018 (index 6) -> pready on the 1st access cycle, pslverr=1, prdata=0, rf_cs never asserted. Same result for a write to 0x7FC.
4. Misaligned: write paddr=0x005 -> pslverr=1, zero wait, and a subsequent read of 0x004 still returns its prior value.
5. Back-to-back: write 0x014=0x12345678 immediately followed by a read of 0x014 (setup in the cycle after pready) -> read returns 0x12345678. Check exactly two rf_cs pulses.
6. Abort: drop psel in RD_CMD -> no pready pulse, bridge back in IDLE, and the next normal read of 0x000 completes in 3 access cycles.
